// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg : shared APB state encoding, default widths and transfer payload
// ---------------------------------------------------------------------------
`default_nettype none

package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   // Sized to the package defaults; users keep ADDR_W/DATA_W at or below them.
   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_payload_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational masked round-robin pick, search starts at rr_ptr+1
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     mask,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   logic [N-1:0] elig;
   assign elig = req & ~mask;

   function automatic logic [IDX_W-1:0] wrap(input int unsigned v);
      return IDX_W'(v % N);
   endfunction

   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      // off == N lands back on rr_ptr itself, so it has the lowest priority
      for (int off = 1; off <= N; off++) begin
         if (!gnt_valid && elig[wrap(32'(rr_ptr) + 32'(off))]) begin
            gnt_valid                          = 1'b1;
            gnt_idx                            = wrap(32'(rr_ptr) + 32'(off));
            gnt[wrap(32'(rr_ptr) + 32'(off))]  = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter : N_REQ requesters sharing one APB completer, round-robin
// ---------------------------------------------------------------------------
`default_nettype none

module apb_req_arbiter
   import apb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        req_write,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0] req_wdata,
   output logic [N_REQ-1:0]        done,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic                    rsp_err,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDR_W-1:0]       PADDR,
   output logic [DATA_W-1:0]       PWDATA,
   input  logic [DATA_W-1:0]       PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR
);

   localparam int              IDX_W  = $clog2(N_REQ);
   localparam int              WC_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

   apb_state_t       state_q, state_d;
   logic [IDX_W-1:0] winner_q, winner_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
   apb_payload_t     payload_q, payload_d;

   logic [N_REQ-1:0]  arb_gnt;
   logic [IDX_W-1:0]  arb_idx;
   logic              arb_valid;
   logic              grant;
   logic              timeout_hit;
   logic              complete;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && (wait_cnt_q == WC_MAX);
   assign complete    = (state_q == ACCESS) && (PREADY || timeout_hit);

   always_comb begin
      done = '0;
      if (complete) begin
         done[winner_q] = 1'b1;
      end
   end

   // Masking with done keeps the finishing requester out of its own completion edge.
   rr_arbiter #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req       (req),
      .mask      (done),
      .rr_ptr    (rr_ptr_q),
      .gnt       (arb_gnt),
      .gnt_idx   (arb_idx),
      .gnt_valid (arb_valid)
   );

   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_gnt[i]) begin
            sel_write = req_write[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      winner_d   = winner_q;
      rr_ptr_d   = rr_ptr_q;
      wait_cnt_d = wait_cnt_q;
      payload_d  = payload_q;
      grant      = 1'b0;
      case (state_q)
         IDLE: begin
            grant = arb_valid;
         end
         SETUP: begin
            state_d    = ACCESS;
            wait_cnt_d = '0;
         end
         ACCESS: begin
            if (complete) begin
               state_d = IDLE;
               grant   = arb_valid;
            end else if (wait_cnt_q != WC_MAX) begin
               wait_cnt_d = wait_cnt_q + WC_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (grant) begin
         state_d         = SETUP;
         winner_d        = arb_idx;
         rr_ptr_d        = arb_idx;
         payload_d.write = sel_write;
         payload_d.addr  = APB_ADDR_W'(sel_addr);
         payload_d.wdata = APB_DATA_W'(sel_wdata);
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q    <= IDLE;
         winner_q   <= '0;
         rr_ptr_q   <= IDX_W'(N_REQ - 1);
         wait_cnt_q <= '0;
         payload_q  <= '0;
      end else begin
         state_q    <= state_d;
         winner_q   <= winner_d;
         rr_ptr_q   <= rr_ptr_d;
         wait_cnt_q <= wait_cnt_d;
         payload_q  <= payload_d;
      end
   end

   assign PSEL      = (state_q != IDLE);
   assign PENABLE   = (state_q == ACCESS);
   assign PWRITE    = payload_q.write;
   assign PADDR     = payload_q.addr[ADDR_W-1:0];
   assign PWDATA    = payload_q.wdata[DATA_W-1:0];
   assign rsp_rdata = (complete && !payload_q.write) ? PRDATA : '0;
   assign rsp_err   = complete && ((PSLVERR && PREADY) || timeout_hit);

endmodule

`default_nettype wire
